// File: rtl/arb_pkg.sv
// Shared definitions for the 4-port round-robin arbiter and its requesters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

    localparam int NUM_PORTS = 4;

    // One-hot request/grant lanes, one per arbiter input (reqN / state_reqN)
    localparam logic [NUM_PORTS-1:0] LANE0 = 4'b0001;
    localparam logic [NUM_PORTS-1:0] LANE1 = 4'b0010;
    localparam logic [NUM_PORTS-1:0] LANE2 = 4'b0100;
    localparam logic [NUM_PORTS-1:0] LANE3 = 4'b1000;

    // Requester handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } req_state_e;

    // Lane constant for a given arbiter port index
    function automatic logic [NUM_PORTS-1:0] lane_onehot(input int unsigned port);
        logic [1:0] w_idx;
        w_idx = port[1:0];
        return LANE0 << w_idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding storage, pointers and occupancy count.
// Latency: pushed word visible at pop_data one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; no bypass.
module sync_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Storage write; contents need no reset since pointers/count define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Per-port requester: buffers packets and releases one per fresh arbiter grant.
// Latency: 4 cycles minimum from push to out_valid; one packet per 4 cycles max.
// Backpressure: in_ready low while FIFO full; pushes while full are dropped.
module arb_requester
    import arb_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] grant,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data
);

    localparam logic [NUM_PORTS-1:0] ONEHOT = lane_onehot(PORT_ID);

    req_state_e              r_state;
    req_state_e              w_next_state;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [$clog2(DEPTH):0]  w_fifo_count;
    logic [DATA_W-1:0]       w_head;
    logic                    w_pop;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Ready reflects registered occupancy only, so a same-cycle pop never raises it
    assign in_ready = !w_fifo_full;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: ARM always precedes WAIT so the grant the arbiter still holds
    // from an earlier round can never be mistaken for a fresh one
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_fifo_count != '0) w_next_state = ARM;
            ARM:  w_next_state = WAIT;
            WAIT: if (grant == ONEHOT) w_next_state = SEND;
            SEND: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: request lane in ARM/WAIT, release and pop the head in SEND
    always_comb begin
        req       = '0;
        out_valid = 1'b0;
        out_data  = '0;
        w_pop     = 1'b0;
        case (r_state)
            ARM, WAIT: req = ONEHOT;
            SEND: begin
                out_valid = 1'b1;
                out_data  = w_head;
                w_pop     = !w_fifo_empty;
            end
            default: req = '0;
        endcase
    end

endmodule
